// File: rtl/miner_scheduler.sv
// miner_scheduler: issues interleaved nonces to LANES hash pipelines,
// aligns returned hash words with issued nonces and queues hits in a FWFT FIFO.
// Optional: MINER_SCHED_STATS_EN adds the 48-bit hashes_done counter.
module miner_scheduler #(
  parameter int LANES      = 4,
  parameter int HASH_LAT   = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic [31:0]           nonce_start,
  input  logic [31:0]           nonce_end,
  input  logic [31:0]           target,
  output logic [LANES*32-1:0]   lane_nonce,
  output logic [LANES-1:0]      lane_valid,
  input  logic [LANES*32-1:0]   hash_word,
  output logic                  found_valid,
  input  logic                  found_ready,
  output logic [31:0]           found_nonce,
  output logic [31:0]           found_hash,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           drop_count
`ifdef MINER_SCHED_STATS_EN
  ,
  output logic [47:0]           hashes_done
`endif
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = AW + 1;
  localparam int CW   = $clog2(HASH_LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t r_state, w_state_nx;

  logic [32:0]         r_base;
  logic [31:0]         r_end;
  logic [31:0]         r_target;
  logic [LANES*32-1:0] r_lane_nonce;
  logic [LANES-1:0]    r_lane_valid;
  logic [CW-1:0]       r_drain_cnt;
  logic [31:0]         r_dl_nonce [HASH_LAT];
  logic [LANES-1:0]    r_dl_mask  [HASH_LAT];
  logic [31:0]         r_fn [FIFO_DEPTH];
  logic [31:0]         r_fh [FIFO_DEPTH];
  logic [AW-1:0]       r_rd, r_wr;
  logic [CNTW-1:0]     r_cnt;
  logic [15:0]         r_drop;

  logic                w_start_ok, w_last, w_issue;
  logic [32:0]         w_next_base;
  logic [31:0]         w_next_end;
  logic [LANES-1:0]    w_next_mask;
  logic [LANES*32-1:0] w_next_nonce;
  logic [31:0]         w_hw [LANES];
  logic [LANES-1:0]    w_hit;
  logic [16:0]         w_hit_cnt, w_drops, w_drop_sum;
  logic [31:0]         w_push_nonce, w_push_hash;
  logic                w_push, w_pop, w_full, w_push_ok;

  // Next issue window: either the freshly loaded range or base+LANES.
  always_comb begin
    w_start_ok   = start && (r_state == S_IDLE || r_state == S_DONE);
    w_next_base  = w_start_ok ? {1'b0, nonce_start} : r_base + 33'(LANES);
    w_next_end   = w_start_ok ? nonce_end : r_end;
    w_last       = (r_base + 33'(LANES - 1)) >= {1'b0, r_end};
    w_issue      = w_start_ok ? (nonce_start <= nonce_end)
                              : (r_state == S_RUN && !stop && !w_last);
    w_next_mask  = '0;
    w_next_nonce = '0;
    for (int i = 0; i < LANES; i++) begin
      w_next_mask[i] = (w_next_base + 33'(i)) <= {1'b0, w_next_end};
      w_next_nonce[i*32 +: 32] = w_next_base[31:0] + 32'(i);
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nx;
  end

  // Next-state logic; start wins over stop outside RUN.
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start)
          w_state_nx = (nonce_start > nonce_end) ? S_DRAIN : S_RUN;
      end
      S_RUN: begin
        if (stop || w_last) w_state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        if (r_drain_cnt == CW'(HASH_LAT - 1)) w_state_nx = S_DONE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Range latch and registered lane outputs; lane_valid is high only in RUN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_base       <= '0;
      r_end        <= '0;
      r_target     <= '0;
      r_lane_nonce <= '0;
      r_lane_valid <= '0;
    end else begin
      if (w_start_ok) begin
        r_end    <= nonce_end;
        r_target <= target;
      end
      if (w_issue) begin
        r_base       <= w_next_base;
        r_lane_nonce <= w_next_nonce;
        r_lane_valid <= w_next_mask;
      end else begin
        r_lane_valid <= '0;
      end
    end
  end

  // Drain timer: HASH_LAT cycles covers every nonce still in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  r_drain_cnt <= '0;
    else if (r_state == S_DRAIN) r_drain_cnt <= r_drain_cnt + 1'b1;
    else                        r_drain_cnt <= '0;
  end

  // Delay line carrying {lane-0 nonce, valid mask} alongside the hashers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < HASH_LAT; k++) begin
        r_dl_nonce[k] <= '0;
        r_dl_mask[k]  <= '0;
      end
    end else begin
      r_dl_nonce[0] <= r_lane_nonce[31:0];
      r_dl_mask[0]  <= r_lane_valid;
      for (int k = 1; k < HASH_LAT; k++) begin
        r_dl_nonce[k] <= r_dl_nonce[k-1];
        r_dl_mask[k]  <= r_dl_mask[k-1];
      end
    end
  end

  // Target compare; lowest hit lane is the push candidate.
  always_comb begin
    w_hit        = '0;
    w_hit_cnt    = '0;
    w_push_nonce = '0;
    w_push_hash  = '0;
    for (int i = 0; i < LANES; i++) begin
      w_hw[i] = {hash_word[i*32 +: 8], hash_word[i*32+8 +: 8],
                 hash_word[i*32+16 +: 8], hash_word[i*32+24 +: 8]};
    end
    for (int i = LANES - 1; i >= 0; i--) begin
      w_hit[i] = r_dl_mask[HASH_LAT-1][i] && (w_hw[i] <= r_target);
      if (r_dl_mask[HASH_LAT-1][i] && (w_hw[i] <= r_target)) begin
        w_push_nonce = r_dl_nonce[HASH_LAT-1] + 32'(i);
        w_push_hash  = w_hw[i];
        w_hit_cnt    = w_hit_cnt + 17'd1;
      end
    end
  end

  // Push/pop arbitration and drop accounting.
  always_comb begin
    w_push     = |w_hit;
    w_pop      = found_valid && found_ready;
    w_full     = (r_cnt == CNTW'(FIFO_DEPTH));
    w_push_ok  = w_push && (!w_full || w_pop);
    w_drops    = (w_push ? w_hit_cnt - 17'd1 : 17'd0)
               + {16'd0, w_push && !w_push_ok};
    w_drop_sum = {1'b0, r_drop} + w_drops;
  end

  // Found FIFO and saturating drop counter; accepted start flushes both.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd   <= '0;
      r_wr   <= '0;
      r_cnt  <= '0;
      r_drop <= '0;
      for (int k = 0; k < FIFO_DEPTH; k++) begin
        r_fn[k] <= '0;
        r_fh[k] <= '0;
      end
    end else if (w_start_ok) begin
      r_rd   <= '0;
      r_wr   <= '0;
      r_cnt  <= '0;
      r_drop <= '0;
    end else begin
      if (w_push_ok) begin
        r_fn[r_wr] <= w_push_nonce;
        r_fh[r_wr] <= w_push_hash;
        r_wr       <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_cnt  <= r_cnt + CNTW'(w_push_ok) - CNTW'(w_pop);
      r_drop <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
    end
  end

`ifdef MINER_SCHED_STATS_EN
  logic [47:0] r_hashes;
  logic [47:0] w_dl_pop;

  // Popcount of lanes leaving the delay line this cycle.
  always_comb begin
    w_dl_pop = '0;
    for (int i = 0; i < LANES; i++)
      w_dl_pop = w_dl_pop + {47'd0, r_dl_mask[HASH_LAT-1][i]};
  end

  // Hashes-checked counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           r_hashes <= '0;
    else if (w_start_ok) r_hashes <= '0;
    else                 r_hashes <= r_hashes + w_dl_pop;
  end

  assign hashes_done = r_hashes;
`endif

  assign lane_nonce  = r_lane_nonce;
  assign lane_valid  = r_lane_valid;
  assign found_valid = (r_cnt != '0);
  assign found_nonce = found_valid ? r_fn[r_rd] : '0;
  assign found_hash  = found_valid ? r_fh[r_rd] : '0;
  assign busy        = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done        = (r_state == S_DONE);
  assign drop_count  = r_drop;

endmodule

// File: tb/tb_miner_scheduler.sv
// tb_miner_scheduler: directed vector table plus stop/reset sequences.
// Hash model: byte-swapped hash = nonce ^ 0xA5A5A5A5, HASH_LAT=8.
module tb_miner_scheduler;

  logic         clk = 0;
  logic         reset = 1;
  logic         start = 0;
  logic         stop = 0;
  logic [31:0]  nonce_start = 0;
  logic [31:0]  nonce_end = 0;
  logic [31:0]  target = 0;
  logic [127:0] lane_nonce;
  logic [3:0]   lane_valid;
  logic [127:0] hash_word;
  logic         found_valid;
  logic         found_ready = 0;
  logic [31:0]  found_nonce;
  logic [31:0]  found_hash;
  logic         busy;
  logic         done;
  logic [15:0]  drop_count;
`ifdef MINER_SCHED_STATS_EN
  logic [47:0]  hashes_done;
`endif

  int total = 0;
  int bad = 0;

  miner_scheduler #(.LANES(4), .HASH_LAT(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .nonce_start(nonce_start), .nonce_end(nonce_end), .target(target),
    .lane_nonce(lane_nonce), .lane_valid(lane_valid),
    .hash_word(hash_word),
    .found_valid(found_valid), .found_ready(found_ready),
    .found_nonce(found_nonce), .found_hash(found_hash),
    .busy(busy), .done(done), .drop_count(drop_count)
`ifdef MINER_SCHED_STATS_EN
    , .hashes_done(hashes_done)
`endif
  );

  always #5 clk = ~clk;

  // External hasher model: HASH_LAT-deep pipe of issued nonces.
  logic [127:0] tb_dn [8];
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 8; k++) tb_dn[k] <= '0;
    end else begin
      tb_dn[0] <= lane_nonce;
      for (int k = 1; k < 8; k++) tb_dn[k] <= tb_dn[k-1];
    end
  end

  always_comb begin
    logic [31:0] x;
    hash_word = '0;
    for (int i = 0; i < 4; i++) begin
      x = tb_dn[7][i*32 +: 32] ^ 32'hA5A5A5A5;
      hash_word[i*32 +: 32] = {x[7:0], x[15:8], x[23:16], x[31:24]};
    end
  end

  typedef struct {
    logic [31:0]      ns, ne, tgt;
    bit               rdy;
    int               cyc, lanes;
    logic [3:0]       m_first, m_last;
    logic [31:0]      mn, mx;
    logic [63:0]      l01;
    int               nfound;
    logic [3:0][31:0] f;
    logic [15:0]      drop;
  } vec_t;

  vec_t vt [6];

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, a, e);
    end
  endtask

  task automatic run_job(input vec_t v);
    int cyc = 0, lanes = 0, drain = 0, nf = 0;
    logic [3:0] mf = 0, ml = 0;
    logic [31:0] mn = 32'hFFFFFFFF, mx = 0, n;
    logic [63:0] l01 = 0;
    logic [3:0][31:0] f = '0;
    @(negedge clk);
    nonce_start = v.ns; nonce_end = v.ne; target = v.tgt;
    found_ready = v.rdy; start = 1;
    @(negedge clk);
    start = 0;
    for (int t = 0; t < 300; t++) begin
      if (lane_valid != 0) begin
        if (cyc == 0) begin
          mf = lane_valid;
          l01 = lane_nonce[63:0];
        end
        cyc++;
        ml = lane_valid;
        for (int i = 0; i < 4; i++) if (lane_valid[i]) begin
          n = lane_nonce[i*32 +: 32];
          lanes++;
          if (n < mn) mn = n;
          if (n > mx) mx = n;
        end
      end else if (busy) drain++;
      if (done) break;
      if (found_valid && found_ready) begin
        if (nf < 4) f[nf] = found_nonce;
        chk("pop_hash", {32'd0, found_hash},
            {32'd0, found_nonce ^ 32'hA5A5A5A5});
        nf++;
      end
      @(negedge clk);
    end
    chk("done", {63'd0, done}, 64'd1);
    chk("drop", {48'd0, drop_count}, {48'd0, v.drop});
    found_ready = 1;
    for (int t = 0; t < 8; t++) begin
      if (found_valid) begin
        if (nf < 4) f[nf] = found_nonce;
        chk("pop_hash", {32'd0, found_hash},
            {32'd0, found_nonce ^ 32'hA5A5A5A5});
        nf++;
      end
      @(negedge clk);
    end
    chk("done_hold", {63'd0, done}, 64'd1);
    chk("issue_cycles", 64'(cyc), 64'(v.cyc));
    chk("lanes_issued", 64'(lanes), 64'(v.lanes));
    chk("mask_first", {60'd0, mf}, {60'd0, v.m_first});
    chk("mask_last", {60'd0, ml}, {60'd0, v.m_last});
    chk("min_nonce", {32'd0, mn}, {32'd0, v.mn});
    chk("max_nonce", {32'd0, mx}, {32'd0, v.mx});
    chk("lane01_first", l01, v.l01);
    chk("drain_cycles", 64'(drain), 64'd8);
    chk("found_count", 64'(nf), 64'(v.nfound));
    for (int k = 0; k < 4; k++)
      if (k < v.nfound)
        chk("found_nonce", {32'd0, f[k]}, {32'd0, v.f[k]});
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_nonce"}, lane_nonce[63:0], 64'd0);
    chk({nm, "_valid"}, {60'd0, lane_valid}, 64'd0);
    chk({nm, "_fvalid"}, {63'd0, found_valid}, 64'd0);
    chk({nm, "_fdata"}, {found_nonce, found_hash}, 64'd0);
    chk({nm, "_flags"}, {62'd0, busy, done}, 64'd0);
    chk({nm, "_drop"}, {48'd0, drop_count}, 64'd0);
  endtask

  initial begin
    vec_t v;
    int nd;
    bit anyv;

    vt[0] = '{32'h100, 32'h10F, 32'hA5A5A4A0, 1'b1, 4, 16, 4'hF, 4'hF,
              32'h100, 32'h10F, {32'h101, 32'h100}, 1,
              {32'd0, 32'd0, 32'd0, 32'h105}, 16'd0};
    vt[1] = '{32'h100, 32'h10F, 32'hA5A5A4A9, 1'b1, 4, 16, 4'hF, 4'hF,
              32'h100, 32'h10F, {32'h101, 32'h100}, 3,
              {32'd0, 32'h10C, 32'h104, 32'h100}, 16'd7};
    vt[2] = '{32'h100, 32'h105, 32'h0, 1'b1, 2, 6, 4'hF, 4'h3,
              32'h100, 32'h105, {32'h101, 32'h100}, 0, '0, 16'd0};
    vt[3] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0, 1'b1, 1, 2, 4'h3, 4'h3,
              32'hFFFFFFFE, 32'hFFFFFFFF, {32'hFFFFFFFF, 32'hFFFFFFFE},
              0, '0, 16'd0};
    vt[4] = '{32'h0, 32'd15, 32'hFFFFFFFF, 1'b0, 4, 16, 4'hF, 4'hF,
              32'h0, 32'hF, {32'h1, 32'h0}, 4,
              {32'd12, 32'd8, 32'd4, 32'd0}, 16'd12};
    vt[5] = '{32'd5, 32'd4, 32'hFFFFFFFF, 1'b1, 0, 0, 4'h0, 4'h0,
              32'hFFFFFFFF, 32'h0, 64'd0, 0, '0, 16'd0};

    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset = 0;

    for (int j = 0; j < 6; j++) run_job(vt[j]);

    // Stop in 2nd RUN cycle; start+stop together from DONE starts.
    @(negedge clk);
    nonce_start = 0; nonce_end = 99; target = 0;
    found_ready = 1; start = 1; stop = 1;
    @(negedge clk);
    start = 0; stop = 0;
    chk("stop_c1_valid", {60'd0, lane_valid}, 64'hF);
    chk("stop_c1_nonce", {32'd0, lane_nonce[31:0]}, 64'd0);
    @(negedge clk);
    chk("stop_c2_valid", {60'd0, lane_valid}, 64'hF);
    chk("stop_c2_nonce", {32'd0, lane_nonce[31:0]}, 64'd4);
    stop = 1;
    @(negedge clk);
    stop = 0;
    chk("stop_c3_valid", {60'd0, lane_valid}, 64'd0);
    nd = 0;
    anyv = 0;
    for (int t = 0; t < 40; t++) begin
      if (done) break;
      if (lane_valid != 0) anyv = 1;
      if (busy) nd++;
      start = (t == 2);
      nonce_start = 32'h500; nonce_end = 32'h5FF;
      @(negedge clk);
    end
    start = 0;
    chk("stop_drain", 64'(nd), 64'd8);
    chk("stop_no_issue", {63'd0, anyv}, 64'd0);
    chk("stop_done", {63'd0, done}, 64'd1);
    chk("stop_nonce_hold", {32'd0, lane_nonce[31:0]}, 64'd4);

    // Reset during DRAIN with two entries queued.
    @(negedge clk);
    nonce_start = 0; nonce_end = 11; target = 32'hFFFFFFFF;
    found_ready = 0; start = 1;
    @(negedge clk);
    start = 0;
    repeat (10) @(negedge clk);
    chk("pre_rst_busy", {62'd0, busy, done}, 64'd2);
    chk("pre_rst_fv", {63'd0, found_valid}, 64'd1);
    chk("pre_rst_head", {32'd0, found_nonce}, 64'd0);
    chk("pre_rst_drop", {48'd0, drop_count}, 64'd6);
    #1 reset = 1;
    #1 chk_zero("async_rst");
    @(negedge clk);
    reset = 0;
    v = vt[0];
    run_job(v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
